// File: rtl/dma_copy.sv
// Single-channel word-copy DMA engine. It is configured through a zero-wait register
// slave port, copies words through a registered req/ack master port, and raises a level interrupt when done.
//
//  state | meaning
//  IDLE  | waiting for a start write
//  RD    | reading a word from src (request held until ack)
//  WR    | writing the buffered word to dst (request held until ack)
//  DONE  | one cycle, sets done-pending
module dma_copy #(
  parameter int LEN_W = 16,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic        req_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        int_sig_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic        m_we_o,
  output logic        m_req_o,
  input  logic [31:0] m_data_i,
  input  logic        m_ack_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [3:0]  A_CTRL = 4'h0;
  localparam logic [3:0]  A_SRC  = 4'h4;
  localparam logic [3:0]  A_DST  = 4'h8;
  localparam logic [3:0]  A_LEN  = 4'hC;
  localparam logic [31:0] STEP_W = 32'(STEP);

  state_t            state, state_nxt;
  logic [31:0]       src, dst, data_buf;
  logic [LEN_W-1:0]  len;
  logic              int_en, pend;
  logic              busy, reg_wr, wr_ctrl, start, xfer_ack, rd_done, wr_done;
  logic              unused_addr;

  assign unused_addr = ^addr_i[31:4];
  assign busy     = (state != IDLE);
  assign reg_wr   = req_i & we_i;
  assign wr_ctrl  = reg_wr && (addr_i[3:0] == A_CTRL);
  assign start    = wr_ctrl && data_i[0] && !busy;
  assign xfer_ack = m_req_o & m_ack_i;
  assign ack_o    = req_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (len == '0) ? DONE : RD;
      RD: if (xfer_ack) begin
        rd_done   = 1'b1;
        state_nxt = WR;
      end
      WR: if (xfer_ack) begin
        wr_done   = 1'b1;
        state_nxt = (len == LEN_W'(1)) ? DONE : RD;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request drops on ack and re-rises one cycle later, giving the one-cycle gap between transfers
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req_o  <= 1'b0;
      m_we_o   <= 1'b0;
      m_addr_o <= '0;
      m_data_o <= '0;
      data_buf <= '0;
    end else if (rd_done || wr_done) begin
      m_req_o <= 1'b0;
      m_we_o  <= 1'b0;
      if (rd_done) data_buf <= m_data_i;
    end else if (state == RD && !m_req_o) begin
      m_req_o  <= 1'b1;
      m_we_o   <= 1'b0;
      m_addr_o <= src;
    end else if (state == WR && !m_req_o) begin
      m_req_o  <= 1'b1;
      m_we_o   <= 1'b1;
      m_addr_o <= dst;
      m_data_o <= data_buf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      len       <= '0;
      int_en    <= 1'b0;
      pend      <= 1'b0;
      int_sig_o <= 1'b0;
    end else begin
      if (reg_wr && !busy && addr_i[3:0] == A_SRC) src <= {data_i[31:2], 2'b00};
      else if (wr_done)                            src <= src + STEP_W;
      if (reg_wr && !busy && addr_i[3:0] == A_DST) dst <= {data_i[31:2], 2'b00};
      else if (wr_done)                            dst <= dst + STEP_W;
      if (reg_wr && !busy && addr_i[3:0] == A_LEN) len <= data_i[LEN_W-1:0];
      else if (wr_done)                            len <= len - LEN_W'(1);
      if (wr_ctrl) int_en <= data_i[1];
      // completion set takes priority over a same-cycle W1C
      if (state == DONE)           pend <= 1'b1;
      else if (wr_ctrl && data_i[2]) pend <= 1'b0;
      int_sig_o <= pend & int_en;
    end
  end

  always_comb begin
    data_o = '0;
    case (addr_i[3:0])
      A_CTRL:  data_o = {28'd0, busy, pend, int_en, 1'b0};
      A_SRC:   data_o = src;
      A_DST:   data_o = dst;
      A_LEN:   data_o = {{(32-LEN_W){1'b0}}, len};
      default: data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_dma_copy.sv
// Directed self-checking bench for dma_copy: a memory responder with programmable
// ack delay logs every master transfer; expectations are hand-derived per scenario.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_i, addr_i, data_o;
  logic        we_i, req_i, ack_o, int_sig_o;
  logic [31:0] m_addr_o, m_data_o, m_data_i;
  logic        m_we_o, m_req_o, m_ack_i;

  dma_copy #(.LEN_W(16), .STEP(4)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i), .req_i(req_i),
    .data_o(data_o), .ack_o(ack_o), .int_sig_o(int_sig_o),
    .m_addr_o(m_addr_o), .m_data_o(m_data_o), .m_we_o(m_we_o), .m_req_o(m_req_o),
    .m_data_i(m_data_i), .m_ack_i(m_ack_i)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int          ack_delay = 0;
  logic        stray_ack = 1'b0;
  int          wait_cnt  = 0;
  int          stable_bad = 0;
  int          req_cycles = 0;
  logic [31:0] ref_addr, ref_data;
  logic        ref_we;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory / peripheral model on the master port
  always @(negedge clk) begin
    if (!m_req_o) begin
      wait_cnt = 0;
      m_ack_i  = stray_ack;
      m_data_i = '0;
    end else begin
      req_cycles++;
      if (wait_cnt == 0) begin
        ref_addr = m_addr_o; ref_we = m_we_o; ref_data = m_data_o;
      end else if (m_addr_o !== ref_addr || m_we_o !== ref_we || m_data_o !== ref_data) begin
        stable_bad++;
      end
      if (wait_cnt >= ack_delay) begin
        m_ack_i  = 1'b1;
        m_data_i = pat(m_addr_o);
        log_addr.push_back(m_addr_o);
        log_we.push_back(m_we_o);
        log_data.push_back(m_we_o ? m_data_o : pat(m_addr_o));
      end else begin
        m_ack_i = 1'b0;
      end
      wait_cnt++;
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b0; addr_i = a;
    #1 d = data_o;
    req_i = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] d;
    int i;
    for (i = 0; i < limit; i++) begin
      bus_rd(32'h0, d);
      if (!d[3]) break;
    end
    if (i == limit) check_val("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_we.delete();
  endtask

  task automatic check_xfers(input string tag, input logic [31:0] s, input logic [31:0] dd, input int n);
    check_val({tag, "_count"}, 32'(log_addr.size()), 32'(2 * n));
    if (log_addr.size() == 2 * n) begin
      for (int i = 0; i < n; i++) begin
        logic [31:0] sa, da;
        sa = s + 32'(4 * i);
        da = dd + 32'(4 * i);
        check_val({tag, "_rd_addr"}, log_addr[2*i], sa);
        check_val({tag, "_rd_we"}, 32'(log_we[2*i]), 32'd0);
        check_val({tag, "_wr_addr"}, log_addr[2*i+1], da);
        check_val({tag, "_wr_we"}, 32'(log_we[2*i+1]), 32'd1);
        check_val({tag, "_wr_data"}, log_data[2*i+1], pat(sa));
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int req_before, i;
    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_m_req", 32'(m_req_o), 32'd0);
    check_val("rst_m_we", 32'(m_we_o), 32'd0);
    check_val("rst_int", 32'(int_sig_o), 32'd0);
    check_val("rst_m_addr", m_addr_o, 32'd0);
    check_val("rst_m_data", m_data_o, 32'd0);
    @(negedge clk) rst = 1'b0;
    bus_rd(32'h0, d); check_val("rst_ctrl", d, 32'h0);
    check_val("ack_o_follows_req", 32'(ack_o), 32'd0);
    bus_rd(32'hC, d); check_val("rst_len", d, 32'h0);

    // 1: three-word copy, immediate acks
    bus_wr(32'h4, 32'h100); bus_wr(32'h8, 32'h200); bus_wr(32'hC, 32'd3);
    clear_log();
    bus_wr(32'h0, 32'h1);
    wait_idle(100);
    check_xfers("t1", 32'h100, 32'h200, 3);
    bus_rd(32'h0, d); check_val("t1_ctrl", d, 32'h4);
    bus_rd(32'hC, d); check_val("t1_len", d, 32'h0);
    bus_rd(32'h4, d); check_val("t1_src", d, 32'h10C);
    bus_rd(32'h8, d); check_val("t1_dst", d, 32'h20C);
    bus_rd(32'h2, d); check_val("t1_unmapped", d, 32'h0);
    bus_wr(32'h1, 32'hFFFF_FFFF);
    bus_rd(32'h4, d); check_val("t1_unmapped_wr", d, 32'h10C);

    // 2: interrupt enable, pending then W1C
    bus_wr(32'h0, 32'h4);
    bus_rd(32'h0, d); check_val("t2_w1c", d, 32'h0);
    bus_wr(32'h4, 32'h100); bus_wr(32'h8, 32'h200); bus_wr(32'hC, 32'd3);
    clear_log();
    bus_wr(32'h0, 32'h3);
    for (i = 0; i < 100; i++) begin
      bus_rd(32'h0, d);
      if (d[2]) break;
    end
    if (i == 100) check_val("t2_pend_timeout", 32'd1, 32'd0);
    check_val("t2_int_lags", 32'(int_sig_o), 32'd0);
    @(negedge clk);
    check_val("t2_int_set", 32'(int_sig_o), 32'd1);
    check_xfers("t2", 32'h100, 32'h200, 3);
    bus_wr(32'h0, 32'h6);
    check_val("t2_int_hold", 32'(int_sig_o), 32'd1);
    @(posedge clk); #1;
    check_val("t2_int_drop", 32'(int_sig_o), 32'd0);
    bus_rd(32'h0, d); check_val("t2_ctrl", d, 32'h2);

    // 3: zero length goes straight to done
    bus_wr(32'h0, 32'h0);
    clear_log();
    req_before = req_cycles;
    bus_wr(32'h0, 32'h1);
    @(posedge clk); #1;
    bus_rd(32'h0, d); check_val("t3_ctrl", d, 32'h4);
    check_val("t3_no_req", 32'(req_cycles - req_before), 32'd0);

    // 4: stray ack while idle, then 5-cycle ack latency
    bus_wr(32'h0, 32'h4);
    stray_ack = 1'b1;
    repeat (4) @(negedge clk);
    stray_ack = 1'b0;
    bus_rd(32'h0, d); check_val("t4_stray_ctrl", d, 32'h0);
    check_val("t4_stray_no_req", 32'(req_cycles - req_before), 32'd0);
    ack_delay = 5; stable_bad = 0;
    bus_wr(32'h4, 32'h300); bus_wr(32'h8, 32'h400); bus_wr(32'hC, 32'd2);
    clear_log();
    bus_wr(32'h0, 32'h1);
    wait_idle(200);
    check_xfers("t4", 32'h300, 32'h400, 2);
    check_val("t4_stable", 32'(stable_bad), 32'd0);

    // 5: pointer wrap, writes while busy ignored
    ack_delay = 0;
    bus_wr(32'h0, 32'h4);
    bus_wr(32'h4, 32'hFFFF_FFFC); bus_wr(32'h8, 32'h500); bus_wr(32'hC, 32'd2);
    clear_log();
    bus_wr(32'h0, 32'h1);
    bus_wr(32'h4, 32'h123); bus_wr(32'hC, 32'd7); bus_wr(32'h8, 32'h999);
    wait_idle(100);
    check_xfers("t5", 32'hFFFF_FFFC, 32'h500, 2);
    bus_rd(32'h4, d); check_val("t5_src_wrap", d, 32'h4);
    bus_rd(32'h8, d); check_val("t5_dst", d, 32'h508);
    bus_rd(32'hC, d); check_val("t5_len", d, 32'h0);
    bus_wr(32'h4, 32'h123);
    bus_rd(32'h4, d); check_val("t5_src_align", d, 32'h120);

    // 6: reset while a read waits for ack
    ack_delay = 1000;
    bus_wr(32'h0, 32'h4);
    bus_wr(32'h4, 32'h600); bus_wr(32'h8, 32'h700); bus_wr(32'hC, 32'd4);
    bus_wr(32'h0, 32'h3);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_req_o) break;
    end
    check_val("t6_req_seen", 32'(m_req_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("t6_req_drop", 32'(m_req_o), 32'd0);
    @(negedge clk) rst = 1'b0;
    ack_delay = 0;
    bus_rd(32'h0, d); check_val("t6_ctrl", d, 32'h0);
    bus_rd(32'h4, d); check_val("t6_src", d, 32'h0);
    bus_rd(32'h8, d); check_val("t6_dst", d, 32'h0);
    bus_rd(32'hC, d); check_val("t6_len", d, 32'h0);
    bus_wr(32'h4, 32'h800); bus_wr(32'h8, 32'h900); bus_wr(32'hC, 32'd1);
    clear_log();
    bus_wr(32'h0, 32'h1);
    wait_idle(100);
    check_xfers("t6", 32'h800, 32'h900, 1);
    bus_rd(32'h0, d); check_val("t6_done", d, 32'h4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
